// File: rtl/lsu_sq_ring.sv
// Program-ordered LSU store queue: circular buffer with commit pointer, oldest-first D$ retire and load forwarding.
// Optional store-to-load forwarding search is enabled by defining LSU_SQ_FWD_EN.

package procyon_lsu_pkg;
  typedef enum logic [2:0] {
    LSU_FUNC_LB,
    LSU_FUNC_LH,
    LSU_FUNC_LW,
    LSU_FUNC_LBU,
    LSU_FUNC_LHU,
    LSU_FUNC_SB,
    LSU_FUNC_SH,
    LSU_FUNC_SW
  } procyon_lsu_func_t;
endpackage

module lsu_sq_ring
  import procyon_lsu_pkg::*;
#(
  parameter int unsigned SQ_DEPTH   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        i_flush,
  output logic                        o_full,
  output logic [$clog2(SQ_DEPTH):0]   o_alloc_idx,
  input  logic                        i_alloc_en,
  input  logic [DATA_WIDTH-1:0]       i_alloc_data,
  input  logic [ADDR_WIDTH-1:0]       i_alloc_addr,
  input  logic [TAG_WIDTH-1:0]        i_alloc_tag,
  input  procyon_lsu_func_t           i_alloc_lsu_func,
  input  logic                        i_rob_retire_en,
  input  logic [TAG_WIDTH-1:0]        i_rob_retire_tag,
  input  logic                        i_sq_retire_stall,
  output logic                        o_sq_retire_en,
  output logic [DATA_WIDTH-1:0]       o_sq_retire_data,
  output logic [ADDR_WIDTH-1:0]       o_sq_retire_addr,
  output logic [TAG_WIDTH-1:0]        o_sq_retire_tag,
  output procyon_lsu_func_t           o_sq_retire_lsu_func,
  input  logic                        i_update_sq_en,
  input  logic                        i_update_sq_retry,
  input  logic                        i_lookup_en,
  input  logic [ADDR_WIDTH-1:0]       i_lookup_addr,
  input  logic [$clog2(SQ_DEPTH):0]   i_lookup_idx,
  output logic                        o_lookup_hit,
  output logic [DATA_WIDTH-1:0]       o_lookup_data,
  output logic                        o_lookup_conflict
);

  localparam int unsigned IDX_W = $clog2(SQ_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        commit_q, commit_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [DATA_WIDTH-1:0]   data_q [SQ_DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_q [SQ_DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_d [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_q  [SQ_DEPTH];
  logic [TAG_WIDTH-1:0]    tag_d  [SQ_DEPTH];
  procyon_lsu_func_t       func_q [SQ_DEPTH];
  procyon_lsu_func_t       func_d [SQ_DEPTH];

  logic [PTR_W-1:0]        count;
  logic [PTR_W-1:0]        lookup_lim;
  logic [IDX_W-1:0]        head_idx, commit_idx, tail_idx;
  logic                    full;
  logic                    alloc_ok, commit_ok, retire_en;

  assign count      = tail_q - head_q;
  assign lookup_lim = i_lookup_idx - head_q;
  assign full       = (count == PTR_W'(SQ_DEPTH));
  assign head_idx   = head_q[IDX_W-1:0];
  assign commit_idx = commit_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];

  assign alloc_ok  = i_alloc_en && !full && !i_flush;
  assign commit_ok = i_rob_retire_en && (commit_q != tail_q) && (tag_q[commit_idx] == i_rob_retire_tag);
  assign retire_en = (state_q == S_IDLE) && (head_q != commit_q) && !i_sq_retire_stall;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    commit_d = commit_q;
    tail_d   = tail_q;
    data_d   = data_q;
    addr_d   = addr_q;
    tag_d    = tag_q;
    func_d   = func_q;

    case (state_q)
      S_IDLE: if (retire_en) state_d = S_WAIT;
      S_WAIT: begin
        if (i_update_sq_en) begin
          state_d = S_IDLE;
          if (!i_update_sq_retry) head_d = head_q + PTR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit_ok) commit_d = commit_q + PTR_W'(1);

    // Flush rewinds tail to the post-commit pointer so a same-cycle commit survives.
    if (i_flush) begin
      tail_d = commit_d;
    end else if (alloc_ok) begin
      tail_d           = tail_q + PTR_W'(1);
      data_d[tail_idx] = i_alloc_data;
      addr_d[tail_idx] = i_alloc_addr;
      tag_d[tail_idx]  = i_alloc_tag;
      func_d[tail_idx] = i_alloc_lsu_func;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      commit_q <= '0;
      tail_q   <= '0;
      for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
        tag_q[i]  <= '0;
        func_q[i] <= LSU_FUNC_LB;
      end
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      commit_q <= commit_d;
      tail_q   <= tail_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      func_q   <= func_d;
    end
  end

  assign o_full               = full;
  assign o_alloc_idx          = tail_q;
  assign o_sq_retire_en       = retire_en;
  assign o_sq_retire_data     = data_q[head_idx];
  assign o_sq_retire_addr     = addr_q[head_idx];
  assign o_sq_retire_tag      = tag_q[head_idx];
  assign o_sq_retire_lsu_func = func_q[head_idx];

`ifdef LSU_SQ_FWD_EN
  logic [PTR_W-1:0] pos;
  logic [IDX_W-1:0] slot;

  // Walk oldest to youngest so the youngest matching store wins.
  always_comb begin
    o_lookup_hit      = 1'b0;
    o_lookup_conflict = 1'b0;
    o_lookup_data     = '0;
    pos               = '0;
    slot              = '0;
    for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
      pos  = head_q + PTR_W'(k);
      slot = pos[IDX_W-1:0];
      if (i_lookup_en && (PTR_W'(k) < lookup_lim) && (PTR_W'(k) < count) &&
          (addr_q[slot][ADDR_WIDTH-1:2] == i_lookup_addr[ADDR_WIDTH-1:2])) begin
        if ((func_q[slot] == LSU_FUNC_SW) && (addr_q[slot] == i_lookup_addr)) begin
          o_lookup_hit      = 1'b1;
          o_lookup_conflict = 1'b0;
          o_lookup_data     = data_q[slot];
        end else begin
          o_lookup_hit      = 1'b0;
          o_lookup_conflict = 1'b1;
          o_lookup_data     = '0;
        end
      end
    end
  end
`else
  logic unused_lookup_addr;
  assign unused_lookup_addr = ^i_lookup_addr;

  assign o_lookup_hit      = 1'b0;
  assign o_lookup_data     = '0;
  assign o_lookup_conflict = i_lookup_en && (lookup_lim != '0) && (count != '0);
`endif

endmodule

// File: tb/tb_lsu_sq_ring.sv
// Self-checking bench for lsu_sq_ring: directed scenarios plus randomized traffic against a queue-level model.
module tb_lsu_sq_ring;
  import procyon_lsu_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic flush, alloc_en, rob_en, stall, upd_en, retry, lookup_en;
  logic [31:0] alloc_data, alloc_addr, lookup_addr;
  logic [5:0]  alloc_tag, rob_tag;
  procyon_lsu_func_t alloc_func;
  logic [3:0]  lookup_idx;

  logic        o_full, o_sq_retire_en, o_lookup_hit, o_lookup_conflict;
  logic [3:0]  o_alloc_idx;
  logic [31:0] o_sq_retire_data, o_sq_retire_addr, o_lookup_data;
  logic [5:0]  o_sq_retire_tag;
  procyon_lsu_func_t o_sq_retire_lsu_func;

  lsu_sq_ring #(.SQ_DEPTH(D), .DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(flush), .o_full(o_full), .o_alloc_idx(o_alloc_idx),
    .i_alloc_en(alloc_en), .i_alloc_data(alloc_data), .i_alloc_addr(alloc_addr),
    .i_alloc_tag(alloc_tag), .i_alloc_lsu_func(alloc_func),
    .i_rob_retire_en(rob_en), .i_rob_retire_tag(rob_tag), .i_sq_retire_stall(stall),
    .o_sq_retire_en(o_sq_retire_en), .o_sq_retire_data(o_sq_retire_data),
    .o_sq_retire_addr(o_sq_retire_addr), .o_sq_retire_tag(o_sq_retire_tag),
    .o_sq_retire_lsu_func(o_sq_retire_lsu_func),
    .i_update_sq_en(upd_en), .i_update_sq_retry(retry),
    .i_lookup_en(lookup_en), .i_lookup_addr(lookup_addr), .i_lookup_idx(lookup_idx),
    .o_lookup_hit(o_lookup_hit), .o_lookup_data(o_lookup_data), .o_lookup_conflict(o_lookup_conflict)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: unbounded sequence numbers for head/commit/tail; hardware pointer = number mod 2*D.
  int m_head, m_commit, m_tail;
  bit m_out;
  logic [31:0] ent_data [D];
  logic [31:0] ent_addr [D];
  logic [5:0]  ent_tag  [D];
  procyon_lsu_func_t ent_func [D];

  int launched_q[$];
  int launched_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; alloc_en = 0; rob_en = 0; stall = 0; upd_en = 0; retry = 0; lookup_en = 0;
    alloc_data = '0; alloc_addr = '0; lookup_addr = '0; alloc_tag = '0; rob_tag = '0;
    alloc_func = LSU_FUNC_SW; lookup_idx = '0;
  endtask

  task automatic model_lookup(output bit hit, output logic [31:0] data, output bit conf);
    int lim, cnt, n;
    hit = 0; data = '0; conf = 0;
    if (lookup_en) begin
      cnt = m_tail - m_head;
      lim = ((int'(lookup_idx) - (m_head % 16)) + 16) % 16;
      n = (lim < cnt) ? lim : cnt;
`ifdef LSU_SQ_FWD_EN
      for (int j = m_head + n - 1; j >= m_head; j--) begin
        if (ent_addr[j % D][31:2] == lookup_addr[31:2]) begin
          if (ent_func[j % D] == LSU_FUNC_SW && ent_addr[j % D] == lookup_addr) begin
            hit = 1; data = ent_data[j % D];
          end else begin
            conf = 1;
          end
          break;
        end
      end
`else
      conf = (n > 0);
`endif
    end
  endtask

  // Compare all outputs against the model, away from the active edge.
  task automatic sample();
    bit exp_en, eh, ec;
    logic [31:0] ed;
    @(negedge clk);
    #1;
    exp_en = n_rst && !m_out && (m_head < m_commit) && !stall;
    chk("full", o_full, (m_tail - m_head) == D);
    chk("alloc_idx", o_alloc_idx, m_tail % 16);
    chk("retire_en", o_sq_retire_en, exp_en);
    if (exp_en) begin
      chk("retire_tag", o_sq_retire_tag, ent_tag[m_head % D]);
      chk("retire_addr", o_sq_retire_addr, ent_addr[m_head % D]);
      chk("retire_data", o_sq_retire_data, ent_data[m_head % D]);
      chk("retire_func", o_sq_retire_lsu_func, ent_func[m_head % D]);
    end
    model_lookup(eh, ed, ec);
    chk("lookup_hit", o_lookup_hit, eh);
    chk("lookup_data", o_lookup_data, ed);
    chk("lookup_conflict", o_lookup_conflict, ec);
    if (o_sq_retire_en) begin
      launched_q.push_back(int'(o_sq_retire_tag));
      launched_cyc.push_back(cyc);
    end
  endtask

  task automatic model_step();
    bit full, alloc_ok, commit_ok, launch;
    full      = (m_tail - m_head) == D;
    alloc_ok  = alloc_en && !full && !flush;
    commit_ok = rob_en && (m_commit < m_tail) && (ent_tag[m_commit % D] == rob_tag);
    launch    = !m_out && (m_head < m_commit) && !stall;
    if (m_out) begin
      if (upd_en) begin
        if (!retry) m_head++;
        m_out = 0;
      end
    end else if (launch) begin
      m_out = 1;
    end
    if (commit_ok) m_commit++;
    if (flush) m_tail = m_commit;
    else if (alloc_ok) begin
      ent_data[m_tail % D] = alloc_data;
      ent_addr[m_tail % D] = alloc_addr;
      ent_tag[m_tail % D]  = alloc_tag;
      ent_func[m_tail % D] = alloc_func;
      m_tail++;
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    if (n_rst) model_step();
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    clear_inputs();
    n_rst = 0;
    m_head = 0; m_commit = 0; m_tail = 0; m_out = 0;
    sample();
    chk("rst_full", o_full, 0);
    chk("rst_idx", o_alloc_idx, 0);
    chk("rst_retire_en", o_sq_retire_en, 0);
    chk("rst_retire_data", o_sq_retire_data, 0);
    chk("rst_retire_addr", o_sq_retire_addr, 0);
    chk("rst_hit", o_lookup_hit, 0);
    chk("rst_conflict", o_lookup_conflict, 0);
    chk("rst_lookup_data", o_lookup_data, 0);
    edge_();
    n_rst = 1;
  endtask

  task automatic alloc_one(input int tag, input logic [31:0] addr, input logic [31:0] data,
                           input procyon_lsu_func_t f);
    clear_inputs();
    alloc_en = 1; alloc_tag = 6'(tag); alloc_addr = addr; alloc_data = data; alloc_func = f;
    sample();
    edge_();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      clear_inputs();
      upd_en = m_out;
      sample();
      edge_();
    end
  endtask

  task automatic do_lookup(input string nm, input bit en, input logic [31:0] addr, input int idx,
                           input bit eh, input logic [31:0] ed, input bit ec);
    clear_inputs();
    lookup_en = en; lookup_addr = addr; lookup_idx = 4'(idx);
    sample();
    chk({nm, "_hit"}, o_lookup_hit, eh);
    chk({nm, "_data"}, o_lookup_data, ed);
    chk({nm, "_conflict"}, o_lookup_conflict, ec);
    edge_();
  endtask

  initial begin
    bit fwd;
    int next_alloc, next_commit, w, cnt;
    bit did_rst;
`ifdef LSU_SQ_FWD_EN
    fwd = 1;
`else
    fwd = 0;
`endif

    // Fill, overflow, commit/launch and retry
    reset_dut();
    for (int i = 1; i <= 8; i++) alloc_one(i, 32'h200 + 32'(4 * (i - 1)), 32'h1000 + 32'(i), LSU_FUNC_SW);
    clear_inputs();
    alloc_en = 1; alloc_tag = 6'd9; alloc_addr = 32'h300; alloc_data = 32'hdead;
    sample();
    chk("full_after_8", o_full, 1);
    chk("idx_after_8", o_alloc_idx, 8);
    edge_();
    clear_inputs(); sample();
    chk("idx_after_drop", o_alloc_idx, 8);
    edge_();

    clear_inputs(); rob_en = 1; rob_tag = 1; sample(); chk("no_launch_before_commit", o_sq_retire_en, 0); edge_();
    clear_inputs(); rob_en = 1; rob_tag = 2; sample();
    chk("launch1_en", o_sq_retire_en, 1); chk("launch1_tag", o_sq_retire_tag, 1); edge_();
    clear_inputs(); upd_en = 1; sample(); chk("wait_no_launch", o_sq_retire_en, 0); edge_();
    clear_inputs(); sample();
    chk("launch2_en", o_sq_retire_en, 1); chk("launch2_tag", o_sq_retire_tag, 2); edge_();
    clear_inputs(); upd_en = 1; sample(); edge_();
    clear_inputs(); rob_en = 1; rob_tag = 3; sample(); chk("head_at_commit", o_sq_retire_en, 0); edge_();
    clear_inputs(); sample();
    chk("launch3_tag", o_sq_retire_tag, 3); chk("launch3_addr", o_sq_retire_addr, 32'h208);
    chk("launch3_data", o_sq_retire_data, 32'h1003); edge_();
    clear_inputs(); upd_en = 1; retry = 1; sample(); edge_();
    clear_inputs(); sample();
    chk("relaunch_en", o_sq_retire_en, 1); chk("relaunch_tag", o_sq_retire_tag, 3);
    chk("relaunch_addr", o_sq_retire_addr, 32'h208); chk("relaunch_data", o_sq_retire_data, 32'h1003);
    edge_();
    clear_inputs(); upd_en = 1; sample(); edge_();
    clear_inputs(); sample(); chk("full_after_retire", o_full, 0); chk("idle_after_retire", o_sq_retire_en, 0); edge_();

    // Flush keeps committed stores
    reset_dut();
    launched_q.delete(); launched_cyc.delete();
    for (int i = 1; i <= 5; i++) alloc_one(i, 32'h400 + 32'(4 * i), 32'h2000 + 32'(i), LSU_FUNC_SW);
    clear_inputs(); rob_en = 1; rob_tag = 1; sample(); edge_();
    clear_inputs(); rob_en = 1; rob_tag = 2; sample(); edge_();
    clear_inputs(); flush = 1; alloc_en = 1; alloc_tag = 9; upd_en = m_out; sample(); edge_();
    clear_inputs(); sample(); chk("flush_idx", o_alloc_idx, 2); chk("flush_full", o_full, 0); edge_();
    drain(8);
    chk("flush_launch_count", launched_q.size(), 2);
    if (launched_q.size() == 2) begin
      chk("flush_launch_0", launched_q[0], 1);
      chk("flush_launch_1", launched_q[1], 2);
      chk("back_to_back_gap", launched_cyc[1] - launched_cyc[0], 2);
    end
    clear_inputs(); sample(); chk("flush_idle", o_sq_retire_en, 0); chk("flush_idx_hold", o_alloc_idx, 2); edge_();

    // Forwarding against two SWs and a younger SB to the same word
    reset_dut();
    alloc_one(1, 32'h100, 32'hAAAA, LSU_FUNC_SW);
    alloc_one(2, 32'h100, 32'hBBBB, LSU_FUNC_SW);
    alloc_one(3, 32'h101, 32'h00CC, LSU_FUNC_SB);
    do_lookup("fwd_young", 1, 32'h100, 2, fwd, fwd ? 32'hBBBB : 32'h0, !fwd);
    do_lookup("fwd_old", 1, 32'h100, 1, fwd, fwd ? 32'hAAAA : 32'h0, !fwd);
    do_lookup("fwd_sb", 1, 32'h100, 3, 0, 32'h0, 1);
    do_lookup("fwd_none", 1, 32'h100, 0, 0, 32'h0, 0);
    do_lookup("fwd_off", 0, 32'h100, 3, 0, 32'h0, 0);
    do_lookup("fwd_other", 1, 32'h180, 3, 0, 32'h0, !fwd);

    // Pointer wrap: 20 stores through the ring in order
    reset_dut();
    launched_q.delete(); launched_cyc.delete();
    next_alloc = 1; next_commit = 1;
    for (int c = 0; c < 400 && launched_q.size() < 20; c++) begin
      clear_inputs();
      stall = ($urandom_range(0, 9) < 3);
      if (next_alloc <= 20) begin
        alloc_en = 1; alloc_tag = 6'(next_alloc);
        alloc_addr = 32'h200 + 32'(4 * (next_alloc % 8)); alloc_data = 32'h3000 + 32'(next_alloc);
        alloc_func = LSU_FUNC_SW;
      end
      if (m_commit < m_tail && next_commit <= 20) begin
        rob_en = 1; rob_tag = 6'(next_commit); next_commit++;
      end
      upd_en = m_out;
      if (alloc_en && (m_tail - m_head) != D) next_alloc++;
      sample();
      edge_();
    end
    chk("wrap_launch_count", launched_q.size(), 20);
    for (int i = 0; i < launched_q.size() && i < 20; i++) chk("wrap_order", launched_q[i], i + 1);

    // Randomized traffic with one reset while a store is outstanding
    reset_dut();
    did_rst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!did_rst && c >= 1500 && m_out) begin
        did_rst = 1;
        reset_dut();
      end
      clear_inputs();
      cnt = m_tail - m_head;
      flush = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 3) == 0);
      alloc_en = ($urandom_range(0, 1) == 1);
      alloc_tag = 6'($urandom);
      alloc_data = $urandom;
      case ($urandom_range(0, 2))
        0: alloc_func = LSU_FUNC_SB;
        1: alloc_func = LSU_FUNC_SH;
        default: alloc_func = LSU_FUNC_SW;
      endcase
      w = $urandom_range(0, 3);
      alloc_addr = 32'h100 + 32'(4 * w);
      if (alloc_func == LSU_FUNC_SB) alloc_addr += 32'($urandom_range(0, 3));
      else if (alloc_func == LSU_FUNC_SH) alloc_addr += 32'(2 * $urandom_range(0, 1));
      else if ($urandom_range(0, 9) == 0) alloc_addr += 2;
      rob_en = ($urandom_range(0, 1) == 1);
      if (m_commit < m_tail && $urandom_range(0, 9) < 6) rob_tag = ent_tag[m_commit % D];
      else rob_tag = 6'($urandom);
      upd_en = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      retry = ($urandom_range(0, 9) < 3);
      lookup_en = ($urandom_range(0, 1) == 1);
      lookup_addr = 32'h100 + 32'(4 * $urandom_range(0, 4)) +
                    (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
      lookup_idx = ($urandom_range(0, 1) == 1) ? 4'(m_tail % 16) : 4'((m_head + $urandom_range(0, cnt)) % 16);
      sample();
      edge_();
    end
    chk("random_reset_taken", did_rst, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_sq_ring.md
# lsu_sq_ring

Parametrised, program-ordered store queue for the LSU. Stores are allocated in program order into a circular buffer, committed when the ROB retires their tag, and written to the D$ strictly oldest-first with one store outstanding at a time and a retry path. Loads probe the queue for store-to-load forwarding against older stores. Sits between LSU_ID (allocate, lookup), the ROB (commit), and LSU_EX/D$ (retire/update).

## Interface
- SQ_DEPTH, 8, entry count; power of two, ≥2
- DATA_WIDTH, 32, store data width
- ADDR_WIDTH, 32, byte address width
- TAG_WIDTH, 6, ROB tag width
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- i_flush  in  1  discard all uncommitted entries
- o_full  out  1  no free entry
- o_alloc_idx  out  $clog2(SQ_DEPTH)+1  current tail pointer (with wrap bit); loads capture it at dispatch
- i_alloc_en / i_alloc_data / i_alloc_addr / i_alloc_tag / i_alloc_lsu_func  in  1/DATA/ADDR/TAG/procyon_lsu_func_t  allocate store at tail
- i_rob_retire_en / i_rob_retire_tag  in  1/TAG  ROB commit
- i_sq_retire_stall  in  1  LSU_EX cannot accept a store
- o_sq_retire_en / _data / _addr / _tag / _lsu_func  out  1/DATA/ADDR/TAG/func  store launched to D$ and LQ
- i_update_sq_en / i_update_sq_retry  in  1/1  result of launched store
- i_lookup_en / i_lookup_addr / i_lookup_idx  in  1/ADDR/$clog2+1  load probe; idx = load's captured o_alloc_idx
- o_lookup_hit / o_lookup_data / o_lookup_conflict  out  1/DATA/1  forwarding result (SQ_FWD_EN only)

## Operation
- Three pointers, each $clog2(SQ_DEPTH)+1 bits with wrap bit: head (oldest), commit (first uncommitted), tail (next free). Invariant head ≤ commit ≤ tail in ring order. Count = tail − head modulo 2·SQ_DEPTH; full when count == SQ_DEPTH.
- Allocate: i_alloc_en && ~o_full writes entry[tail], tail++. Allocate while full is dropped.
- Commit: i_rob_retire_en && commit≠tail && entry[commit].tag == i_rob_retire_tag → commit++. Non-matching tags ignored (non-store retirements).
- Retire FSM, states IDLE, WAIT:
  - IDLE: o_sq_retire_en = (head≠commit) && ~i_sq_retire_stall, outputs driven from entry[head]; when asserted → WAIT.
  - WAIT: o_sq_retire_en = 0. i_update_sq_en && ~retry → head++, IDLE. i_update_sq_en && retry → IDLE (same head relaunched). Update in IDLE ignored.
- Flush: tail ← commit; committed entries and FSM state untouched; concurrent allocate dropped; concurrent commit still applies, and tail ← commit+1 in that case.
- Forwarding: candidates are valid entries in [head, i_lookup_idx). Youngest candidate with addr[ADDR_WIDTH-1:2] matching selected. Full-word SW with exact address → hit, data = entry data. Match with SB/SH or unaligned overlap → conflict (load must replay), hit=0. No candidate → hit=0, conflict=0. An entry launched and awaiting update still counts.

## Timing
- Reset: head=commit=tail=0, FSM IDLE, o_full=0, o_alloc_idx=0, o_sq_retire_en=0, o_lookup_hit=0, o_lookup_conflict=0, data outputs 0.
- Allocate/commit/flush/pointer updates take effect next edge; o_full, o_alloc_idx registered-pointer derived.
- Retire: earliest launch the cycle after commit (commit→launch latency 1); update accepted ≥1 cycle after launch; back-to-back stores launch every 2 cycles minimum.
- Lookup combinational, same cycle as i_lookup_en; outputs 0 when i_lookup_en=0.
- Simultaneous allocate + head++ when full: allocate still dropped (full sampled before update).
- Reset mid-WAIT: all state cleared; outstanding update ignored.

## Configuration
- LSU_SQ_FWD_EN defined: forwarding logic and o_lookup_* present as above.
- Undefined: no search logic; o_lookup_hit=0 and o_lookup_data=0 always; o_lookup_conflict = 1 whenever i_lookup_en and any valid entry lies in [head, i_lookup_idx) (conservative replay).

## Test plan
- Fill SQ_DEPTH=8 with tags 1–8 → o_full=1 after 8th; 9th allocate dropped, tail wraps to 8 (wrap bit set, index 0).
- Commit tags 1,2; no stall → launches tag 1, update success, launches tag 2 two cycles later; head=2.
- Launch tag 3, update retry → tag 3 relaunched next IDLE cycle with identical addr/data.
- 5 allocated, 2 committed, flush → tail=commit=2, launches of tags 1,2 complete normally, o_full=0.
- SW 0x100=0xAAAA then SW 0x100=0xBBBB, lookup 0x100 with idx after both → hit, data 0xBBBB; idx between them → 0xAAAA; SB 0x101 younger included → conflict=1.
- Pointer wrap: 20 alloc/commit/retire cycles at depth 8 → correct order, no spurious full/empty.
